sdram_request_arbiter: RTL and testbench
========================================

Name: sdram_request_arbiter

Overview:
Shares the single-command SDRAM controller between two independent requesters: port A (playback reader) and port B (recording writer). The block is a simple request/ack client on each side and sequences the controller's inputValid / recievedCommand / outputValid / isBusy handshake. Arbitration is round-robin. A watchdog guarantees that every request is acknowledged, either with data or with a timeout flag.

Parameters:
ADDR_WIDTH, 25, SDRAM word address {bank[24:23], row[22:10], column[9:0]}
DATA_WIDTH, 16, SDRAM data word width
TIMEOUT_CYCLES, 4096, maximum cycles spent in ISSUE plus WAIT_DONE before a forced timeout ack

Ports:
activeClock  input  1  single clock (same 143 MHz clock as the SDRAM controller)
reset  input  1  synchronous, active-high reset
portA_request  input  1  level; address, writeData and isWriting are held stable until portA_ack
portA_address  input  ADDR_WIDTH  target word
portA_writeData  input  DATA_WIDTH  write data
portA_isWriting  input  1  1 = write, 0 = read
portA_ack  output  1  one-cycle completion pulse
portA_readData  output  DATA_WIDTH  read result, valid while portA_ack=1
portA_timeout  output  1  valid with portA_ack; 1 = request abandoned
portB_*  same seven signals as port A
sdram_address  output  ADDR_WIDTH  to controller address
sdram_inputData  output  DATA_WIDTH  to controller inputData
sdram_isWriting  output  1  to controller isWriting
sdram_inputValid  output  1  to controller inputValid
sdram_outputData  input  DATA_WIDTH  from controller outputData
sdram_outputValid  input  1  from controller; one-cycle read-data pulse
sdram_isBusy  input  1  from controller; includes autorefresh busy
sdram_recievedCommand  input  1  from controller; command accepted
activePort  output  1  0 = A, 1 = B; value of the current or last grant
arbiterBusy  output  1  high in every state except IDLE

Behaviour:
- Reset values, all registered: every output 0, state IDLE, lastGrant = B (so A wins the first tie), watchdog 0, sawBusy 0.
- Reset asserted mid-operation: the block returns to IDLE next cycle and drops sdram_inputValid. No ack is issued for the interrupted request.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant that port.
  - Both requesting: grant the port that is not lastGrant.
  - On grant: latch address, writeData and isWriting into the sdram_* outputs, set activePort, clear the watchdog and sawBusy, go to ISSUE.
- ISSUE:
  - sdram_inputValid = 1 for the whole state; sdram_* outputs hold their values.
  - On sdram_recievedCommand = 1: go to WAIT_DONE, and sdram_inputValid = 0 from the next cycle.
  - sdram_inputValid staying high for one cycle after acceptance is legal, because the controller is busy and ignores it.
- WAIT_DONE, read: on sdram_outputValid = 1, capture sdram_outputData into a result register and go to RESPOND.
- WAIT_DONE, write:
  - sawBusy sets on any cycle with sdram_isBusy = 1.
  - Complete on the first cycle with sdram_isBusy = 0 and sawBusy = 1, then go to RESPOND.
  - An autorefresh that follows the write only delays the ack; that is correct behaviour.
- RESPOND:
  - Exactly one cycle: granted portX_ack = 1, portX_readData = captured data (0 for writes), portX_timeout = 0.
  - lastGrant = activePort; go to IDLE.
  - The non-granted port's ack, readData and timeout stay 0.
  - readData and timeout are 0 whenever ack = 0.
- Watchdog:
  - Increments every cycle in ISSUE and WAIT_DONE; clears on entry to ISSUE; saturates, no wrap.
  - On reaching TIMEOUT_CYCLES-1 in either state: drop sdram_inputValid, go to RESPOND with timeout = 1 and readData = 0.
  - A completion event in the same cycle as the timeout takes priority: normal ack with timeout = 0.
- Requester rules:
  - Requester must deassert request, or present a new transaction, in the cycle after ack.
  - Request still high in IDLE is treated as a new transaction.
  - Minimum turnaround: grant no earlier than the cycle after RESPOND.
- Request dropped before ack: protocol violation. The transaction still completes and acks.
- Latency: request high in IDLE at cycle t → sdram_inputValid = 1 at t+1; ack = 1 exactly one cycle after the completion event.
- Arithmetic: watchdog width = $clog2(TIMEOUT_CYCLES)+1; no other arithmetic.

Test Plan:
- Single read: A reads 0x0000403 with a controller model returning 0xBEEF → sdram_inputValid at t+1; portA_ack once with readData=0xBEEF and timeout=0; portB_ack stays 0.
- Single write: B writes 0x1234 to 0x1800005 → sdram_address=0x1800005, sdram_isWriting=1, sdram_inputData=0x1234; portB_ack exactly one cycle after the model's isBusy falls.
- Contention: A and B request in the same cycle right after reset, both held → A served first, then B, then A; activePort sequence 0,1,0; never two consecutive grants to the same port while both request.
- Autorefresh stall: model holds isBusy=1 for 10 cycles before accepting → inputValid held continuously; request accepted; correct ack with no duplicate command (exactly one recievedCommand-acknowledged issue).
- Timeout: TIMEOUT_CYCLES=64, model never asserts recievedCommand → portA_ack with timeout=1 and readData=0 at cycle 64 after issue; inputValid low afterwards; B is then served normally.
- Reset mid-read: assert reset in WAIT_DONE → next cycle all outputs are 0, no ack, and A is granted first on the next tie.

Source files
------------

// File: rtl/sdram_request_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sdram_request_arbiter
// Purpose  : Round-robin arbiter that shares a single-command SDRAM
//            controller between two request/ack clients (A = playback
//            reader, B = recording writer). Sequences the controller
//            handshake and guarantees every request is acknowledged,
//            either with data or with a timeout flag.
// Ports    : activeClock, reset      - clock, synchronous active-high reset
//            portX_request/address/writeData/isWriting - client request
//            portX_ack/readData/timeout                - client completion
//            sdram_*                  - controller command / status
//            activePort               - current or last grant (0 = A)
//            arbiterBusy              - high whenever not idle
// Revision : 1.0 - initial release
// ============================================================================
module sdram_request_arbiter #(
    parameter int ADDR_WIDTH     = 25,
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  activeClock,
    input  logic                  reset,
    input  logic                  portA_request,
    input  logic [ADDR_WIDTH-1:0] portA_address,
    input  logic [DATA_WIDTH-1:0] portA_writeData,
    input  logic                  portA_isWriting,
    output logic                  portA_ack,
    output logic [DATA_WIDTH-1:0] portA_readData,
    output logic                  portA_timeout,
    input  logic                  portB_request,
    input  logic [ADDR_WIDTH-1:0] portB_address,
    input  logic [DATA_WIDTH-1:0] portB_writeData,
    input  logic                  portB_isWriting,
    output logic                  portB_ack,
    output logic [DATA_WIDTH-1:0] portB_readData,
    output logic                  portB_timeout,
    output logic [ADDR_WIDTH-1:0] sdram_address,
    output logic [DATA_WIDTH-1:0] sdram_inputData,
    output logic                  sdram_isWriting,
    output logic                  sdram_inputValid,
    input  logic [DATA_WIDTH-1:0] sdram_outputData,
    input  logic                  sdram_outputValid,
    input  logic                  sdram_isBusy,
    input  logic                  sdram_recievedCommand,
    output logic                  activePort,
    output logic                  arbiterBusy
);

    localparam int              c_WD_W     = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [c_WD_W-1:0] c_WD_LIMIT = c_WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_WD_W-1:0] c_WD_MAX   = '1;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_DONE = 2'd2,
        S_RESPOND   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic                r_last_grant;
    logic [c_WD_W-1:0]   r_watchdog;
    logic                r_saw_busy;

    logic w_any_request;
    logic w_grant_port;
    logic w_in_flight;
    logic w_read_done;
    logic w_write_done;
    logic w_done;
    logic w_timeout;
    logic w_finish;

    // Tie goes to the port that did not win last; a lone requester always wins.
    assign w_any_request = portA_request | portB_request;
    assign w_grant_port  = (portA_request & portB_request) ? ~r_last_grant : ~portA_request;

    assign w_in_flight  = (r_state == S_ISSUE) || (r_state == S_WAIT_DONE);
    assign w_read_done  = (r_state == S_WAIT_DONE) && !sdram_isWriting && sdram_outputValid;
    // A write is finished once the controller has gone busy and come back;
    // a trailing autorefresh simply stretches the busy window.
    assign w_write_done = (r_state == S_WAIT_DONE) && sdram_isWriting && !sdram_isBusy && r_saw_busy;
    assign w_done       = w_read_done | w_write_done;
    // A genuine completion on the expiry cycle wins over the timeout.
    assign w_timeout    = w_in_flight && (r_watchdog == c_WD_LIMIT) && !w_done;
    assign w_finish     = w_done | w_timeout;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_any_request) begin
                    w_next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (w_timeout) begin
                    w_next_state = S_RESPOND;
                end else if (sdram_recievedCommand) begin
                    w_next_state = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (w_finish) begin
                    w_next_state = S_RESPOND;
                end
            end
            S_RESPOND: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge activeClock) begin
        if (reset) begin
            r_state          <= S_IDLE;
            r_last_grant     <= 1'b1;
            r_watchdog       <= '0;
            r_saw_busy       <= 1'b0;
            sdram_address    <= '0;
            sdram_inputData  <= '0;
            sdram_isWriting  <= 1'b0;
            sdram_inputValid <= 1'b0;
            activePort       <= 1'b0;
            arbiterBusy      <= 1'b0;
            portA_ack        <= 1'b0;
            portA_readData   <= '0;
            portA_timeout    <= 1'b0;
            portB_ack        <= 1'b0;
            portB_readData   <= '0;
            portB_timeout    <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            arbiterBusy <= (w_next_state != S_IDLE);

            // Completion outputs are single-cycle pulses; zero unless set below.
            portA_ack      <= 1'b0;
            portA_readData <= '0;
            portA_timeout  <= 1'b0;
            portB_ack      <= 1'b0;
            portB_readData <= '0;
            portB_timeout  <= 1'b0;

            if (w_in_flight && (r_watchdog != c_WD_MAX)) begin
                r_watchdog <= r_watchdog + c_WD_W'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (w_any_request) begin
                        activePort       <= w_grant_port;
                        sdram_address    <= w_grant_port ? portB_address   : portA_address;
                        sdram_inputData  <= w_grant_port ? portB_writeData : portA_writeData;
                        sdram_isWriting  <= w_grant_port ? portB_isWriting : portA_isWriting;
                        sdram_inputValid <= 1'b1;
                        r_watchdog       <= '0;
                        r_saw_busy       <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    if (w_timeout || sdram_recievedCommand) begin
                        sdram_inputValid <= 1'b0;
                    end
                end
                S_WAIT_DONE: begin
                    if (sdram_isBusy) begin
                        r_saw_busy <= 1'b1;
                    end
                end
                S_RESPOND: begin
                    r_last_grant <= activePort;
                end
                default: begin
                end
            endcase

            if (w_finish) begin
                if (activePort) begin
                    portB_ack      <= 1'b1;
                    portB_readData <= w_read_done ? sdram_outputData : '0;
                    portB_timeout  <= w_timeout;
                end else begin
                    portA_ack      <= 1'b1;
                    portA_readData <= w_read_done ? sdram_outputData : '0;
                    portA_timeout  <= w_timeout;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sdram_request_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_request_arbiter
// Purpose  : Directed self-checking bench for sdram_request_arbiter. The
//            SDRAM controller responses are driven step by step from the
//            stimulus sequence; expected values are hand-computed constants.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_request_arbiter;

    localparam int c_AW = 25;
    localparam int c_DW = 16;

    logic            activeClock;
    logic            reset;
    logic            portA_request;
    logic [c_AW-1:0] portA_address;
    logic [c_DW-1:0] portA_writeData;
    logic            portA_isWriting;
    logic            portA_ack;
    logic [c_DW-1:0] portA_readData;
    logic            portA_timeout;
    logic            portB_request;
    logic [c_AW-1:0] portB_address;
    logic [c_DW-1:0] portB_writeData;
    logic            portB_isWriting;
    logic            portB_ack;
    logic [c_DW-1:0] portB_readData;
    logic            portB_timeout;
    logic [c_AW-1:0] sdram_address;
    logic [c_DW-1:0] sdram_inputData;
    logic            sdram_isWriting;
    logic            sdram_inputValid;
    logic [c_DW-1:0] sdram_outputData;
    logic            sdram_outputValid;
    logic            sdram_isBusy;
    logic            sdram_recievedCommand;
    logic            activePort;
    logic            arbiterBusy;

    int checks;
    int failures;

    sdram_request_arbiter #(
        .ADDR_WIDTH    (c_AW),
        .DATA_WIDTH    (c_DW),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .activeClock          (activeClock),
        .reset                (reset),
        .portA_request        (portA_request),
        .portA_address        (portA_address),
        .portA_writeData      (portA_writeData),
        .portA_isWriting      (portA_isWriting),
        .portA_ack            (portA_ack),
        .portA_readData       (portA_readData),
        .portA_timeout        (portA_timeout),
        .portB_request        (portB_request),
        .portB_address        (portB_address),
        .portB_writeData      (portB_writeData),
        .portB_isWriting      (portB_isWriting),
        .portB_ack            (portB_ack),
        .portB_readData       (portB_readData),
        .portB_timeout        (portB_timeout),
        .sdram_address        (sdram_address),
        .sdram_inputData      (sdram_inputData),
        .sdram_isWriting      (sdram_isWriting),
        .sdram_inputValid     (sdram_inputValid),
        .sdram_outputData     (sdram_outputData),
        .sdram_outputValid    (sdram_outputValid),
        .sdram_isBusy         (sdram_isBusy),
        .sdram_recievedCommand(sdram_recievedCommand),
        .activePort           (activePort),
        .arbiterBusy          (arbiterBusy)
    );

    initial activeClock = 1'b0;
    always #5 activeClock = ~activeClock;

    // Advance one clock; outputs are then sampled and inputs driven 1 ns
    // after the rising edge.
    task automatic tick();
        @(posedge activeClock);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [127:0] all_outputs();
        return 128'({sdram_address, sdram_inputData, sdram_isWriting, sdram_inputValid,
                     activePort, arbiterBusy, portA_ack, portA_readData, portA_timeout,
                     portB_ack, portB_readData, portB_timeout});
    endfunction

    // Controller accepts the pending command, then returns read data.
    // Returns with the arbiter in its respond cycle.
    task automatic complete_read(input logic [c_DW-1:0] data);
        sdram_recievedCommand = 1'b1;
        tick();
        sdram_recievedCommand = 1'b0;
        sdram_outputValid     = 1'b1;
        sdram_outputData      = data;
        tick();
        sdram_outputValid     = 1'b0;
        sdram_outputData      = '0;
    endtask

    initial begin
        logic held;
        checks   = 0;
        failures = 0;
        reset                 = 1'b1;
        portA_request         = 1'b0;
        portA_address         = '0;
        portA_writeData       = '0;
        portA_isWriting       = 1'b0;
        portB_request         = 1'b0;
        portB_address         = '0;
        portB_writeData       = '0;
        portB_isWriting       = 1'b0;
        sdram_outputData      = '0;
        sdram_outputValid     = 1'b0;
        sdram_isBusy          = 1'b0;
        sdram_recievedCommand = 1'b0;

        // ---------------- reset state
        tick();
        tick();
        check("reset_outputs", all_outputs(), 128'h0);
        reset = 1'b0;

        // ---------------- single read on A
        portA_request   = 1'b1;
        portA_address   = 25'h0000403;
        portA_isWriting = 1'b0;
        tick();
        check("rd_inputValid", 128'(sdram_inputValid), 128'h1);
        check("rd_address", 128'(sdram_address), 128'h0000403);
        check("rd_activePort", 128'(activePort), 128'h0);
        check("rd_busy", 128'(arbiterBusy), 128'h1);
        complete_read(16'hBEEF);
        check("rd_ackA", 128'({portA_ack, portA_readData, portA_timeout}), 128'h1_BEEF_0 >> 0 == 0 ? 128'h0 : {110'h0, 1'b1, 16'hBEEF, 1'b0});
        check("rd_ackB_idle", 128'({portB_ack, portB_readData, portB_timeout}), 128'h0);
        check("rd_inputValid_low", 128'(sdram_inputValid), 128'h0);
        portA_request = 1'b0;
        tick();
        check("rd_ack_pulse", 128'({portA_ack, portA_readData, arbiterBusy}), 128'h0);

        // ---------------- single write on B
        portB_request   = 1'b1;
        portB_address   = 25'h1800005;
        portB_writeData = 16'h1234;
        portB_isWriting = 1'b1;
        tick();
        check("wr_cmd", 128'({sdram_address, sdram_inputData, sdram_isWriting, sdram_inputValid, activePort}),
              {83'h0, 25'h1800005, 16'h1234, 1'b1, 1'b1, 1'b1});
        sdram_recievedCommand = 1'b1;
        tick();
        sdram_recievedCommand = 1'b0;
        sdram_isBusy          = 1'b1;
        tick();
        tick();
        check("wr_no_early_ack", 128'(portB_ack), 128'h0);
        sdram_isBusy = 1'b0;
        tick();
        check("wr_ackB", 128'({portB_ack, portB_readData, portB_timeout}), {110'h0, 1'b1, 16'h0, 1'b0});
        check("wr_ackA_idle", 128'(portA_ack), 128'h0);
        portB_request   = 1'b0;
        portB_isWriting = 1'b0;
        tick();

        // ---------------- contention right after reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        portA_request = 1'b1;
        portA_address = 25'h0000010;
        portB_request = 1'b1;
        portB_address = 25'h0000020;
        tick();
        check("rr_first_A", 128'({activePort, sdram_address}), {102'h0, 1'b0, 25'h0000010});
        complete_read(16'h1111);
        check("rr_ackA", 128'({portA_ack, portA_readData, portB_ack}), {111'h0, 1'b1, 16'h1111, 1'b0});
        tick();
        tick();
        check("rr_second_B", 128'({activePort, sdram_address, sdram_inputValid}), {101'h0, 1'b1, 25'h0000020, 1'b1});
        complete_read(16'h2222);
        check("rr_ackB", 128'({portB_ack, portB_readData, portA_ack}), {111'h0, 1'b1, 16'h2222, 1'b0});
        tick();
        tick();
        check("rr_third_A", 128'(activePort), 128'h0);
        portB_request = 1'b0;
        complete_read(16'h3333);
        check("rr_ackA2", 128'({portA_ack, portA_readData}), {111'h0, 1'b1, 16'h3333});
        portA_request = 1'b0;
        tick();

        // ---------------- autorefresh stall before acceptance
        portA_request = 1'b1;
        portA_address = 25'h0123456;
        tick();
        sdram_isBusy = 1'b1;
        held = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            held = held & sdram_inputValid & ~portA_ack;
        end
        check("stall_inputValid_held", 128'(held), 128'h1);
        sdram_isBusy          = 1'b0;
        sdram_recievedCommand = 1'b1;
        tick();
        sdram_recievedCommand = 1'b0;
        held = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            held = held | sdram_inputValid;
        end
        check("stall_no_reissue", 128'(held), 128'h0);
        sdram_outputValid = 1'b1;
        sdram_outputData  = 16'hCAFE;
        tick();
        sdram_outputValid = 1'b0;
        sdram_outputData  = '0;
        check("stall_ackA", 128'({portA_ack, portA_readData, portA_timeout}), {110'h0, 1'b1, 16'hCAFE, 1'b0});
        portA_request = 1'b0;
        tick();

        // ---------------- timeout: controller never accepts
        portA_request = 1'b1;
        portA_address = 25'h0000777;
        tick();
        held = 1'b1;
        for (int i = 0; i < 63; i++) begin
            tick();
            held = held & sdram_inputValid & ~portA_ack;
        end
        check("to_wait_63", 128'(held), 128'h1);
        tick();
        check("to_ackA", 128'({portA_ack, portA_readData, portA_timeout}), {110'h0, 1'b1, 16'h0, 1'b1});
        check("to_inputValid_low", 128'(sdram_inputValid), 128'h0);
        portA_request = 1'b0;
        portB_request = 1'b1;
        portB_address = 25'h0000888;
        tick();
        tick();
        check("to_then_B", 128'({activePort, sdram_inputValid, sdram_address}), {101'h0, 1'b1, 1'b1, 25'h0000888});
        complete_read(16'h5A5A);
        check("to_ackB", 128'({portB_ack, portB_readData, portB_timeout}), {110'h0, 1'b1, 16'h5A5A, 1'b0});
        portB_request = 1'b0;
        tick();

        // ---------------- reset in WAIT_DONE (last grant A beforehand)
        portA_request = 1'b1;
        portA_address = 25'h0000042;
        tick();
        complete_read(16'h0042);
        check("rst_pre_ackA", 128'(portA_ack), 128'h1);
        tick();
        tick();
        check("rst_regrant_A", 128'(activePort), 128'h0);
        sdram_recievedCommand = 1'b1;
        tick();
        sdram_recievedCommand = 1'b0;
        reset             = 1'b1;
        sdram_outputValid = 1'b1;
        sdram_outputData  = 16'hDEAD;
        tick();
        sdram_outputValid = 1'b0;
        sdram_outputData  = '0;
        check("rst_outputs_zero", all_outputs(), 128'h0);
        reset         = 1'b0;
        portB_request = 1'b1;
        tick();
        check("rst_tie_A_first", 128'({activePort, sdram_inputValid, portA_ack}), {125'h0, 1'b0, 1'b1, 1'b0});
        portB_request = 1'b0;
        complete_read(16'h7777);
        check("rst_ackA_after", 128'({portA_ack, portA_readData}), {111'h0, 1'b1, 16'h7777});
        portA_request = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
